bit_plane_serializer: RTL and testbench
=======================================

BIT_PLANE_SERIALIZER -- requirements
Module: bit_plane_serializer

Interface
REQ-001 SHALL have parameter: M, default 32, number of operands (bits per output plane), M >= 2.
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  single clock, all logic on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 start_i  in  1  one-cycle request to begin a transfer
 num_bytes_i  in  16  bytes per operand N, sampled at accepted start_i
 wr_vld_i  in  1  operand byte valid
 wr_rdy_o  out  1  operand byte ready
 wr_byte_i  in  8  operand byte
 data_o  out  M  bit plane: data_o[j] = bit b of operand j
 data_vld_o  out  1  data_o valid this cycle
 num_bytes_o  out  16  latched N, stable while busy_o
 busy_o  out  1  transfer in progress
 done_o  out  1  one-cycle pulse after the last plane
REQ-003 SHALL treat a write as accepted when wr_vld_i and wr_rdy_o are both high on a rising edge.

Function
REQ-004 SHALL use states IDLE and RUN; start_i in IDLE with num_bytes_i != 0 -> RUN, latch num_bytes_o, busy_o=1 next cycle.
REQ-005 SHALL ignore start_i in RUN, and ignore start_i with num_bytes_i == 0 (remain IDLE, no done_o).
REQ-006 SHALL take writes in order: operand 0..M-1 of byte 0, then operand 0..M-1 of byte 1, ... up to byte N-1.
REQ-007 SHALL buffer bytes in two banks of M x 8 bits (ping-pong); M accepted writes fill a bank and mark it full.
REQ-008 SHALL drive wr_rdy_o = RUN && a non-full bank exists && fewer than N*M writes accepted; wr_rdy_o=0 in IDLE.
REQ-009 SHALL drain a full bank as 8 consecutive planes, b=0..7 (LSB first), one per cycle with data_vld_o=1; data_vld_o=0 when no full bank is available.
REQ-010 SHALL register outputs: first plane appears the cycle after the M-th write of a byte is accepted.
REQ-011 SHALL release a bank for writing in the cycle after its plane 7; if the other bank is already full, its plane 0 follows plane 7 with no gap (8*N back-to-back cycles when the writer keeps up).
REQ-012 SHALL allow a write into the free bank in the same cycle the other bank drains.
REQ-013 SHALL drive data_o = 0 whenever data_vld_o = 0.
REQ-014 SHALL pulse done_o the cycle after plane 7 of byte N-1, clear busy_o at the same time, and return to IDLE.
REQ-015 SHALL use a 16-bit byte counter; N = 65535 completes without wrap error.

Reset
REQ-016 SHALL, on rst_n low, asynchronously force IDLE, both banks empty, all counters 0, and data_o, data_vld_o, wr_rdy_o, busy_o, done_o, num_bytes_o to 0.
REQ-017 SHALL discard any partial transfer on mid-operation reset; the next transfer requires a new start_i.

Configuration
REQ-018 SHALL honour macro BPS_PLANE_CNT_EN: when defined, add output plane_cnt_o (20 bits) counting planes emitted since the last accepted start_i (cleared at start and reset); when undefined, the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-019 SHALL place the state enum, BYTE_W=8, NUM_BYTES_W=16 and the default M in shared package bps_pkg.
REQ-020 SHALL implement each bank as sub-module bps_plane_bank (byte write by operand index, bit-plane read by bit index), instantiated twice.

Verification (bench M=4; data_o shown as {op3,op2,op1,op0})
REQ-021 SHALL cover: N=1, bytes 0x01,0x02,0x04,0x80 -> planes 0001,0010,0100,0000,0000,0000,0000,1000 on 8 consecutive cycles; done_o one cycle after the last plane.
REQ-022 SHALL cover: N=2, writer at full rate -> 16 consecutive data_vld_o cycles; byte-1 planes immediately follow byte-0 plane 7.
REQ-023 SHALL cover: writer stalls 20 cycles after 3 of 4 byte-1 writes -> data_vld_o low through the stall; byte-1 plane 0 the cycle after the 4th write.
REQ-024 SHALL cover: both banks full, writer holds wr_vld_i -> wr_rdy_o low until the cycle after plane 7 of the first bank.
REQ-025 SHALL cover: start_i with num_bytes_i=0 -> busy_o stays 0, wr_rdy_o stays 0, no done_o.
REQ-026 SHALL cover: rst_n low during plane 3 -> all outputs 0 immediately; after release, writes are refused until a new start_i.

Source files
------------

// File: rtl/bps_pkg.sv
// Shared definitions for the bit-plane serializer: state encoding,
// byte/count widths and the default operand count.
package bps_pkg;

  localparam int BYTE_W      = 8;
  localparam int NUM_BYTES_W = 16;
  localparam int M_DEFAULT   = 32;
  localparam int PLANE_CNT_W = 20;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bps_state_e;

endpackage

// File: rtl/bps_plane_bank.sv
// One ping-pong bank: M operand bytes written by operand index and read
// back as a bit plane (bit rd_bit of every operand).
module bps_plane_bank
  import bps_pkg::*;
#(
  parameter int M = M_DEFAULT,
  localparam int IDX_W = $clog2(M)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BYTE_W-1:0] wr_byte,
  input  logic [2:0]        rd_bit,
  output logic [M-1:0]      plane
);

  logic [BYTE_W-1:0] mem [M];

  // Byte storage; contents are only meaningful while the owner marks the bank full.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_byte;
  end

  // Gather the selected bit of every operand into one plane.
  always_comb begin
    plane = '0;
    for (int j = 0; j < M; j++) plane[j] = mem[j][rd_bit];
  end

endmodule

// File: rtl/bit_plane_serializer.sv
// Bit-plane serializer: collects N bytes for each of M operands through a
// two-bank ping-pong buffer and emits each byte group as 8 bit planes,
// LSB first. Optional macro BPS_PLANE_CNT_EN adds the plane_cnt_o counter.
module bit_plane_serializer
  import bps_pkg::*;
#(
  parameter int M = M_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [NUM_BYTES_W-1:0] num_bytes_i,
  input  logic                   wr_vld_i,
  output logic                   wr_rdy_o,
  input  logic [BYTE_W-1:0]      wr_byte_i,
  output logic [M-1:0]           data_o,
  output logic                   data_vld_o,
  output logic [NUM_BYTES_W-1:0] num_bytes_o,
  output logic                   busy_o,
  output logic                   done_o
`ifdef BPS_PLANE_CNT_EN
  ,
  output logic [PLANE_CNT_W-1:0] plane_cnt_o
`endif
);

  localparam int IDX_W = $clog2(M);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

  bps_state_e state, state_nxt;

  logic [NUM_BYTES_W-1:0] num_bytes_q;
  logic [NUM_BYTES_W-1:0] wr_bytes_q;   // byte groups completely written
  logic [NUM_BYTES_W-1:0] rd_bytes_q;   // byte groups completely drained
  logic [IDX_W-1:0]       op_idx_q;     // next operand slot in the write bank
  logic                   wr_bank_q;
  logic                   rd_bank_q;
  logic [1:0]             full_q;
  logic [2:0]             bit_idx_q;
  logic                   done_q;

  logic       start_acc;
  logic       wr_acc;
  logic       wr_last_op;
  logic       plane_vld;
  logic       plane_last;
  logic       xfer_last;
  logic [1:0] full_set;
  logic [1:0] full_clr;
  logic [M-1:0] plane0;
  logic [M-1:0] plane1;

  // Next-state and handshake decode; everything here depends only on flops
  // and start_i, so wr_rdy_o and the plane outputs carry no input-to-output path.
  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    wr_rdy_o   = 1'b0;
    plane_vld  = 1'b0;
    plane_last = 1'b0;
    xfer_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && (num_bytes_i != '0)) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // The writer always targets the bank after the one it last filled,
        // so that bank being full means both are full.
        wr_rdy_o   = !full_q[wr_bank_q] && (wr_bytes_q < num_bytes_q);
        plane_vld  = full_q[rd_bank_q];
        plane_last = plane_vld && (bit_idx_q == 3'd7);
        xfer_last  = plane_last && (rd_bytes_q == (num_bytes_q - 16'd1));
        if (xfer_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_acc     = wr_vld_i && wr_rdy_o;
  assign wr_last_op = wr_acc && (op_idx_q == LAST_IDX);
  // Set and clear never hit the same bank in one cycle: set needs it empty,
  // clear needs it full.
  assign full_set   = wr_last_op ? {wr_bank_q, ~wr_bank_q} : 2'b00;
  assign full_clr   = plane_last ? {rd_bank_q, ~rd_bank_q} : 2'b00;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Write/read pointers, bank occupancy and transfer counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_bytes_q <= '0;
      wr_bytes_q  <= '0;
      rd_bytes_q  <= '0;
      op_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      bit_idx_q   <= 3'd0;
    end else if (start_acc) begin
      num_bytes_q <= num_bytes_i;
      wr_bytes_q  <= '0;
      rd_bytes_q  <= '0;
      op_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      bit_idx_q   <= 3'd0;
    end else begin
      if (wr_acc) begin
        if (wr_last_op) begin
          op_idx_q   <= '0;
          wr_bank_q  <= ~wr_bank_q;
          wr_bytes_q <= wr_bytes_q + 16'd1;
        end else begin
          op_idx_q <= op_idx_q + IDX_W'(1);
        end
      end
      if (plane_vld) begin
        bit_idx_q <= bit_idx_q + 3'd1;
        if (plane_last) begin
          rd_bank_q  <= ~rd_bank_q;
          rd_bytes_q <= rd_bytes_q + 16'd1;
        end
      end
      full_q <= (full_q | full_set) & ~full_clr;
    end
  end

  // One-cycle completion pulse, coincident with the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= xfer_last;
  end

  bps_plane_bank #(.M(M)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_acc && !wr_bank_q),
    .wr_idx  (op_idx_q),
    .wr_byte (wr_byte_i),
    .rd_bit  (bit_idx_q),
    .plane   (plane0)
  );

  bps_plane_bank #(.M(M)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_acc && wr_bank_q),
    .wr_idx  (op_idx_q),
    .wr_byte (wr_byte_i),
    .rd_bit  (bit_idx_q),
    .plane   (plane1)
  );

  assign data_vld_o  = plane_vld;
  assign data_o      = plane_vld ? (rd_bank_q ? plane1 : plane0) : '0;
  assign busy_o      = (state == RUN);
  assign done_o      = done_q;
  assign num_bytes_o = num_bytes_q;

`ifdef BPS_PLANE_CNT_EN
  logic [PLANE_CNT_W-1:0] plane_cnt_q;

  // Planes emitted since the last accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         plane_cnt_q <= '0;
    else if (start_acc) plane_cnt_q <= '0;
    else if (plane_vld) plane_cnt_q <= plane_cnt_q + PLANE_CNT_W'(1);
  end

  assign plane_cnt_o = plane_cnt_q;
`endif

endmodule

// File: tb/tb_bit_plane_serializer.sv
// Self-checking bench for bit_plane_serializer with M=4 and a plane scoreboard.
`timescale 1ns/1ps
module tb_bit_plane_serializer;

  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [15:0]  num_bytes_i = '0;
  logic         wr_vld_i = 1'b0;
  logic [7:0]   wr_byte_i = '0;
  logic         wr_rdy_o;
  logic [M-1:0] data_o;
  logic         data_vld_o;
  logic [15:0]  num_bytes_o;
  logic         busy_o;
  logic         done_o;
`ifdef BPS_PLANE_CNT_EN
  logic [19:0]  plane_cnt_o;
`endif

  bit_plane_serializer #(.M(M)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .num_bytes_i (num_bytes_i),
    .wr_vld_i    (wr_vld_i),
    .wr_rdy_o    (wr_rdy_o),
    .wr_byte_i   (wr_byte_i),
    .data_o      (data_o),
    .data_vld_o  (data_vld_o),
    .num_bytes_o (num_bytes_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef BPS_PLANE_CNT_EN
    ,
    .plane_cnt_o (plane_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  logic [M-1:0] sb_q[$];
  logic [7:0]   op_buf [M];
  int done_cnt = 0;
  int last_vld_cyc = -10;
  int run_len = 0;
  int max_run = 0;
  int p7_cyc = -10;
  int plane_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid plane.
  always @(negedge clk) begin
    if (data_vld_o) begin
      if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      else chk($sformatf("plane%0d", plane_seen % 8), 32'(data_o), 32'(sb_q.pop_front()));
      run_len = (last_vld_cyc == cyc - 1) ? run_len + 1 : 1;
      if (run_len > max_run) max_run = run_len;
      if (plane_seen % 8 == 7) p7_cyc = cyc;
      plane_seen++;
      last_vld_cyc = cyc;
    end else begin
      chk("idle_data_zero", 32'(data_o), 32'd0);
    end
    if (done_o) begin
      done_cnt++;
      chk("done_after_p7", 32'(cyc - last_vld_cyc), 32'd1);
      chk("done_busy_clr", 32'(busy_o), 32'd0);
      chk("done_sb_empty", 32'(sb_q.size()), 32'd0);
    end
  end

  task automatic finish_fatal(input string why);
    $display("FAIL %s: bound expired", why);
    nerr++;
    nchk++;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "aborted");
  endtask

  // One operand byte; returns cycles spent waiting for ready and the cycle it was accepted in.
  task automatic write_op(input int j, input logic [7:0] val, output int waits, output int acc_cyc);
    logic [M-1:0] p;
    waits = 0;
    @(negedge clk);
    wr_vld_i  = 1'b1;
    wr_byte_i = val;
    while (!wr_rdy_o) begin
      waits++;
      if (waits > 300) finish_fatal("wr_rdy_timeout");
      @(negedge clk);
    end
    acc_cyc = cyc;
    @(posedge clk);
    op_buf[j] = val;
    if (j == M - 1) begin
      for (int b = 0; b < 8; b++) begin
        for (int k = 0; k < M; k++) p[k] = op_buf[k][b];
        sb_q.push_back(p);
      end
    end
  endtask

  task automatic write_bytes(input logic [8*M-1:0] v);
    int w;
    int a;
    for (int j = 0; j < M; j++) write_op(j, v[8*j +: 8], w, a);
  endtask

  task automatic wr_stop();
    @(negedge clk);
    wr_vld_i = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    @(negedge clk);
    start_i     = 1'b1;
    num_bytes_i = n;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_cnt == prev && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done_cnt), 32'(prev + 1));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    finish_fatal("watchdog");
  end

  initial begin
    int prev;
    int w;
    int a;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_vld", 32'(data_vld_o), 32'd0);
    chk("rst_rdy", 32'(wr_rdy_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_nbytes", 32'(num_bytes_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // N=1, one-hot style operands
    prev = done_cnt; max_run = 0;
    do_start(16'd1);
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_nbytes", 32'(num_bytes_o), 32'd1);
    write_bytes({8'h80, 8'h04, 8'h02, 8'h01});
    wr_stop();
    wait_done(prev);
    chk("t1_run", 32'(max_run), 32'd8);

    // N=2 at full rate; a start during RUN is ignored
    prev = done_cnt; max_run = 0;
    do_start(16'd2);
    write_bytes(32'h5A3CF00F);
    write_bytes(32'($urandom));
    wr_stop();
    do_start(16'd5);
    chk("t2_nbytes_hold", 32'(num_bytes_o), 32'd2);
    chk("t2_busy_hold", 32'(busy_o), 32'd1);
    wait_done(prev);
    chk("t2_run", 32'(max_run), 32'd16);
    repeat (2) @(negedge clk);
    chk("t2_no_restart", 32'(busy_o), 32'd0);

    // N=2 with a 20-cycle writer stall before the last operand of byte 1
    prev = done_cnt; max_run = 0;
    do_start(16'd2);
    write_bytes(32'($urandom));
    write_op(0, 8'hC3, w, a);
    write_op(1, 8'h7E, w, a);
    write_op(2, 8'h81, w, a);
    wr_stop();
    repeat (20) @(negedge clk);
    chk("t3_stall_vld", 32'(data_vld_o), 32'd0);
    write_op(3, 8'h18, w, a);
    wr_stop();
    chk("t3_p0_next", 32'(data_vld_o), 32'd1);
    wait_done(prev);
    chk("t3_run", 32'(max_run), 32'd8);

    // N=3: both banks full, writer held off until the cycle after plane 7
    prev = done_cnt; max_run = 0;
    do_start(16'd3);
    write_bytes(32'($urandom));
    write_bytes(32'($urandom));
    write_op(0, 8'hA5, w, a);
    chk("t4_rdy_held", 32'(w > 0), 32'd1);
    chk("t4_rdy_after_p7", 32'(a), 32'(p7_cyc + 1));
    write_op(1, 8'h3C, w, a);
    write_op(2, 8'hFF, w, a);
    write_op(3, 8'h00, w, a);
    wr_stop();
    wait_done(prev);
    chk("t4_run", 32'(max_run), 32'd24);

    // N=0 start is ignored
    prev = done_cnt;
    do_start(16'd0);
    wr_vld_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_busy", 32'(busy_o), 32'd0);
      chk("t5_rdy", 32'(wr_rdy_o), 32'd0);
      @(negedge clk);
    end
    wr_vld_i = 1'b0;
    chk("t5_no_done", 32'(done_cnt), 32'(prev));

    // Reset while plane 3 is on the output
    do_start(16'd1);
    write_bytes(32'($urandom));
    wr_stop();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data", 32'(data_o), 32'd0);
    chk("t6_vld", 32'(data_vld_o), 32'd0);
    chk("t6_rdy", 32'(wr_rdy_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_done", 32'(done_o), 32'd0);
    chk("t6_nbytes", 32'(num_bytes_o), 32'd0);
    sb_q.delete();
    plane_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_vld_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_rdy_refused", 32'(wr_rdy_o), 32'd0);
    end
    wr_vld_i = 1'b0;

    // Fresh transfer after reset
    prev = done_cnt; max_run = 0;
    do_start(16'd1);
    write_bytes({8'hFF, 8'h00, 8'hAA, 8'h55});
    wr_stop();
    wait_done(prev);
    chk("t7_run", 32'(max_run), 32'd8);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
